sobel_edge3x3: RTL and testbench

Pipelined Sobel edge detector sitting directly downstream of the 3×3 sliding-window stage in the satellite image pipeline. Each accepted window yields a saturated 8-bit gradient magnitude and a thresholded edge flag. An internal column/row tracker suppresses windows that straddle a line wrap or the frame top, so only interior centres are emitted. Output stream carries valid, start-of-frame, end-of-line and end-of-frame markers for the downstream compression/packetising stage.

---
 rtl/sobel_edge3x3.sv | 168 ++++++++++++++++
 tb/tb_sobel_edge3x3.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge3x3.sv
// Three-stage Sobel gradient magnitude with edge flag for a 3x3 window stream.
// A position tracker keeps only windows whose centre lies inside the frame.
module sobel_edge3x3 #(
  parameter int W = 3124,
  parameter int H = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] p00,
  input  logic [7:0] p01,
  input  logic [7:0] p02,
  input  logic [7:0] p10,
  input  logic [7:0] p11,
  input  logic [7:0] p12,
  input  logic [7:0] p20,
  input  logic [7:0] p21,
  input  logic [7:0] p22,
  input  logic [7:0] threshold,
  output logic [7:0] out_mag,
  output logic       out_edge,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  // Stream semantics: no backpressure. A cycle with in_valid=1 carries one
  // pixel; every stage's *_valid marks a live result and bubbles simply flow.

  // Tracker registers hold the coordinate expected for the next valid pixel.
  logic [XW-1:0] x_q, cur_x;
  logic [YW-1:0] y_q, cur_y;
  logic          act_q, cur_act;
  logic          accept;

  always_comb begin
    cur_x   = x_q;
    cur_y   = y_q;
    cur_act = act_q;
    if (in_valid && in_sof) begin
      cur_x   = '0;
      cur_y   = '0;
      cur_act = 1'b1;
    end
  end

  assign accept = in_valid && cur_act && (cur_x >= XW'(2)) && (cur_y >= YW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b0;
    end else if (in_valid && cur_act) begin
      act_q <= 1'b1;
      if (cur_x == X_LAST) begin
        x_q <= '0;
        if (cur_y == Y_LAST) begin
          y_q   <= '0;
          act_q <= 1'b0;
        end else begin
          y_q <= cur_y + 1'b1;
        end
      end else begin
        x_q <= cur_x + 1'b1;
        y_q <= cur_y;
      end
    end
  end

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] abs_diff(input logic [9:0] pos, input logic [9:0] neg);
    logic [10:0] d;
    d = {1'b0, pos} - {1'b0, neg};
    return d[10] ? 10'(-d) : d[9:0];
  endfunction

  // Stage 1: weighted triple sums
  logic       s1_valid, s1_sof, s1_eol, s1_eof;
  logic [9:0] s1_gxp, s1_gxn, s1_gyp, s1_gyn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_gxp   <= '0;
      s1_gxn   <= '0;
      s1_gyp   <= '0;
      s1_gyn   <= '0;
    end else begin
      s1_valid <= accept;
      s1_sof   <= accept && (cur_x == XW'(2)) && (cur_y == YW'(2));
      s1_eol   <= accept && (cur_x == X_LAST);
      s1_eof   <= accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
      if (accept) begin
        s1_gxp <= wsum(p02, p12, p22);
        s1_gxn <= wsum(p00, p10, p20);
        s1_gyp <= wsum(p20, p21, p22);
        s1_gyn <= wsum(p00, p01, p02);
      end
    end
  end

  // Stage 2: signed differences folded to magnitudes
  logic       s2_valid, s2_sof, s2_eol, s2_eof;
  logic [9:0] s2_ax, s2_ay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
      s2_ax    <= '0;
      s2_ay    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
      if (s1_valid) begin
        s2_ax <= abs_diff(s1_gxp, s1_gxn);
        s2_ay <= abs_diff(s1_gyp, s1_gyn);
      end
    end
  end

  // Stage 3: sum, saturate to 8 bits, threshold
  logic [10:0] mag;
  logic [7:0]  mag_sat;

  assign mag     = {1'b0, s2_ax} + {1'b0, s2_ay};
  assign mag_sat = (|mag[10:8]) ? 8'hff : mag[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      out_eol   <= s2_eol;
      out_eof   <= s2_eof;
      if (s2_valid) begin
        out_mag  <= mag_sat;
        out_edge <= (mag_sat >= threshold);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge3x3.sv
// Directed bench for sobel_edge3x3 on an 8x6 frame: hand-derived magnitudes
// per test image, marker and latency checks through an expected queue.
module tb_sobel_edge3x3;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof;
  logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [7:0] threshold;
  logic [7:0] out_mag;
  logic       out_edge, out_valid, out_sof, out_eol, out_eof;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  int c0;

  logic [11:0] exp_q[$];
  int          exp_cyc_q[$];

  sobel_edge3x3 #(.W(W), .H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22), .threshold(threshold),
    .out_mag(out_mag), .out_edge(out_edge), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Test images: 0 flat 100, 1 vertical step at column 4, 2 dot 255 at (3,3), 3 dot 50 at (3,3)
  function automatic logic [7:0] pix(input int sel, input int px, input int py);
    if (px < 0 || py < 0) return 8'd0;
    case (sel)
      0: return 8'd100;
      1: return (px >= 4) ? 8'd200 : 8'd0;
      2: return (px == 3 && py == 3) ? 8'd255 : 8'd0;
      default: return (px == 3 && py == 3) ? 8'd50 : 8'd0;
    endcase
  endfunction

  // Hand-derived magnitude at each centre for each image
  function automatic logic [7:0] exp_mag(input int sel, input int cx, input int cy);
    bit nb;
    nb = (cx >= 2 && cx <= 4 && cy >= 2 && cy <= 4 && !(cx == 3 && cy == 3));
    case (sel)
      0: return 8'd0;
      1: return (cx == 3 || cx == 4) ? 8'd255 : 8'd0;
      2: return nb ? 8'd255 : 8'd0;
      default: return nb ? 8'd100 : 8'd0;
    endcase
  endfunction

  // driver tasks
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drive_px(input int x, input int y, input bit sof, input bit acc, input int sel);
    logic [7:0] m;
    logic       s, l, f;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    p00 = pix(sel, x-2, y-2); p01 = pix(sel, x-1, y-2); p02 = pix(sel, x, y-2);
    p10 = pix(sel, x-2, y-1); p11 = pix(sel, x-1, y-1); p12 = pix(sel, x, y-1);
    p20 = pix(sel, x-2, y);   p21 = pix(sel, x-1, y);   p22 = pix(sel, x, y);
    if (acc) begin
      m = exp_mag(sel, x-1, y-1);
      s = (x == 2 && y == 2);
      l = (x == W-1);
      f = (x == W-1 && y == H-1);
      exp_q.push_back({s, l, f, (m >= threshold), m});
      exp_cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic drive_frame(input int sel, input logic [7:0] thr, input int n, input bit gaps);
    if (threshold !== thr) begin
      repeat (4) idle();
      threshold = thr;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      drive_px(i % W, i / W, (i == 0), ((i % W) >= 2 && (i / W) >= 2), sel);
    end
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [11:0] e;
    int          c;
    if (!rst) begin
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("mag", 32'(out_mag), 32'(e[7:0]));
          check("edge", 32'(out_edge), 32'(e[8]));
          check("marks", 32'({out_sof, out_eol, out_eof}), 32'(e[11:9]));
          check("lat", cyc, c);
        end
      end else begin
        check("marks_nv", 32'({out_sof, out_eol, out_eof}), 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; threshold = 8'd1;
    {p00, p01, p02, p10, p11, p12, p20, p21, p22} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_mag", 32'(out_mag), 0);
    check("rst_marks", 32'({out_edge, out_sof, out_eol, out_eof}), 0);
    @(negedge clk) rst = 1'b0;

    // pixels before any sof are ignored
    c0 = out_cnt;
    for (int i = 0; i < 12; i++) drive_px(i % W, i / W, 1'b0, 1'b0, 1);
    drain();
    check("pre_sof_cnt", out_cnt - c0, 0);

    // flat frame, threshold 1
    c0 = out_cnt;
    drive_frame(0, 8'd1, W*H, 1'b0);
    drain();
    check("flat_cnt", out_cnt - c0, 24);

    // pixels after frame end are ignored
    c0 = out_cnt;
    for (int i = 0; i < 20; i++) drive_px(i % W, 3, 1'b0, 1'b0, 1);
    drain();
    check("post_eof_cnt", out_cnt - c0, 0);

    // vertical step, continuous then with random gaps
    c0 = out_cnt;
    drive_frame(1, 8'd128, W*H, 1'b0);
    drain();
    check("step_cnt", out_cnt - c0, 24);
    c0 = out_cnt;
    drive_frame(1, 8'd128, W*H, 1'b1);
    drain();
    check("step_gap_cnt", out_cnt - c0, 24);

    // single bright pixels, threshold on the boundary
    drive_frame(2, 8'd255, W*H, 1'b0);
    drain();
    drive_frame(3, 8'd100, W*H, 1'b0);
    drain();
    drive_frame(3, 8'd101, W*H, 1'b1);
    drain();

    // sof mid-frame at row 3 restarts the frame
    c0 = out_cnt;
    drive_frame(1, 8'd128, 3*W + 4, 1'b0);
    drive_frame(1, 8'd128, W*H, 1'b0);
    drain();
    check("midsof_cnt", out_cnt - c0, 32);

    // sof in place of the eof window: that centre is lost
    c0 = out_cnt;
    drive_frame(2, 8'd255, W*H - 1, 1'b0);
    drive_frame(2, 8'd255, W*H, 1'b0);
    drain();
    check("eofsof_cnt", out_cnt - c0, 47);

    // async reset pulse mid-frame while results are in flight
    drive_frame(1, 8'd128, 20, 1'b0);
    idle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_mag", 32'(out_mag), 0);
    check("mrst_marks", 32'({out_edge, out_sof, out_eol, out_eof}), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    c0 = out_cnt;
    for (int i = 0; i < 30; i++) drive_px(i % W, i / W, 1'b0, 1'b0, 1);
    drain();
    check("mrst_nosof_cnt", out_cnt - c0, 0);
    c0 = out_cnt;
    drive_frame(1, 8'd128, W*H, 1'b0);
    drain();
    check("mrst_frame_cnt", out_cnt - c0, 24);

    repeat (3) idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
